pipe_hazard_ctrl: RTL and testbench

Hazard scheduler for the 5-stage pipeline. It watches ID and EX stage fields and sequences the pipeline registers. It drives the PC hold, the IF/ID hold and flush, and the ID/EX bubble for four cases: load-use hazards, multiply/divide occupancy, and taken-branch or register-jump redirects. It also owns the mul/div busy counter and two saturating performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard scheduler: ID/EX stage fields in, pipeline
// register controls, mul/div status and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             MemRd_EX;
  logic [4:0]       rt_EX;
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             useRs_ID;
  logic             useRt_ID;
  logic             muldiv_start_ID;
  logic             muldiv_use_ID;
  logic             Branch_taken_EX;
  logic             JumpReg_EX;
  logic             cnt_clr;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             muldiv_busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output MemRd_EX, rt_EX, rs_ID, rt_ID, useRs_ID, useRt_ID,
           muldiv_start_ID, muldiv_use_ID, Branch_taken_EX, JumpReg_EX, cnt_clr,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, muldiv_busy,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  MemRd_EX, rt_EX, rs_ID, rt_ID, useRs_ID, useRt_ID,
           muldiv_start_ID, muldiv_use_ID, Branch_taken_EX, JumpReg_EX, cnt_clr,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, muldiv_busy,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: load-use and mul/div stalls,
// branch/jr flushes, mul/div occupancy counter and stall/flush perf counters.
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LDUSE  = 2'd1,
    MDWAIT = 2'd2
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES);

  state_t     state_reg;
  logic [7:0] md_cnt_reg;
  logic       redirect;
  logic       rs_match;
  logic       rt_match;
  logic       ld_haz;
  logic       md_haz;
  logic       md_accept;
  logic       muldiv_busy;
  logic       hold;
  logic       flush;
  logic       bubble;
  logic [1:0] cnt_inc;

  assign redirect    = hz.Branch_taken_EX | hz.JumpReg_EX;
  assign rs_match    = hz.useRs_ID && (hz.rs_ID == hz.rt_EX);
  assign rt_match    = hz.useRt_ID && (hz.rt_ID == hz.rt_EX);
  assign ld_haz      = hz.MemRd_EX && (hz.rt_EX != 5'd0) && (rs_match || rt_match);
  assign muldiv_busy = (md_cnt_reg != 8'd0);
  assign md_haz      = muldiv_busy && (hz.muldiv_start_ID || hz.muldiv_use_ID);
  assign md_accept   = hz.muldiv_start_ID && !md_haz && !ld_haz && !redirect;

  // Controls are gated by reset so the pipeline runs freely the instant rst drops.
  always_comb begin
    hold   = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    if (rst) begin
      if (redirect) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (md_haz || ld_haz) begin
        hold   = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  // A redirect leaves md_cnt alone: the op in flight is older than the branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_reg <= 8'd0;
    end else if (md_accept) begin
      md_cnt_reg <= MD_LOAD;
    end else if (muldiv_busy) begin
      md_cnt_reg <= md_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
    end else if (redirect) begin
      state_reg <= RUN;
    end else if (md_haz) begin
      state_reg <= MDWAIT;
    end else if (ld_haz) begin
      state_reg <= LDUSE;
    end else begin
      state_reg <= RUN;
    end
  end

  assign cnt_inc = {flush, hold};

  // Index 0 counts stall cycles, index 1 counts redirect cycles.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (hz.cnt_clr) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign hz.pc_hold     = hold;
  assign hz.ifid_hold   = hold;
  assign hz.ifid_flush  = flush;
  assign hz.idex_bubble = bubble;
  assign hz.muldiv_busy = muldiv_busy;
  assign hz.state       = state_reg;
  assign hz.stall_cnt   = gen_cnt[0].cnt_reg;
  assign hz.flush_cnt   = gen_cnt[1].cnt_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int MDC  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: remaining mul/div cycles, stall reason, counters.
  int   m_md, m_state, m_stall, m_flush;
  logic e_redir, e_md, e_ld, e_hold, e_flush, e_bubble;

  function void model_reset();
    m_md = 0; m_state = 0; m_stall = 0; m_flush = 0;
  endfunction

  function void model_eval();
    e_redir  = bus.Branch_taken_EX || bus.JumpReg_EX;
    e_ld     = bus.MemRd_EX && (bus.rt_EX != 0) &&
               ((bus.useRs_ID && bus.rs_ID == bus.rt_EX) || (bus.useRt_ID && bus.rt_ID == bus.rt_EX));
    e_md     = (m_md > 0) && (bus.muldiv_start_ID || bus.muldiv_use_ID);
    e_hold   = rst && !e_redir && (e_md || e_ld);
    e_flush  = rst && e_redir;
    e_bubble = rst && (e_redir || e_md || e_ld);
  endfunction

  function void model_tick();
    bit accept;
    model_eval();
    accept  = bus.muldiv_start_ID && !e_md && !e_ld && !e_redir;
    m_state = e_redir ? 0 : (e_md ? 2 : (e_ld ? 1 : 0));
    m_md    = accept ? MDC : (m_md > 0 ? m_md - 1 : 0);
    if (bus.cnt_clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e_hold && m_stall < CMAX) m_stall++;
      if (e_flush && m_flush < CMAX) m_flush++;
    end
  endfunction

  task automatic advance();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MemRd_EX = 0; bus.rt_EX = 0; bus.rs_ID = 0; bus.rt_ID = 0;
    bus.useRs_ID = 0; bus.useRt_ID = 0; bus.muldiv_start_ID = 0; bus.muldiv_use_ID = 0;
    bus.Branch_taken_EX = 0; bus.JumpReg_EX = 0; bus.cnt_clr = 0;
  endtask

  task automatic clear_counters();
    idle();
    bus.cnt_clr = 1;
    advance();
    bus.cnt_clr = 0;
  endtask

  task automatic load_use_inputs();
    idle();
    bus.MemRd_EX = 1; bus.rt_EX = 5'd8; bus.rs_ID = 5'd8; bus.useRs_ID = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    load_use_inputs();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy});
    end
    checks++;
    if ({bus.state, bus.stall_cnt, bus.flush_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_regs got state=%0d stall=%0d flush=%0d want 0 0 0",
               bus.state, bus.stall_cnt, bus.flush_cnt);
    end
    @(negedge clk);
    rst = 1;
    idle();
    @(posedge clk);
    #1;
    $display("reset: outputs forced low and registers cleared");
  endtask

  task automatic test_load_use();
    clear_counters();
    load_use_inputs();
    @(negedge clk);
    checks++;
    if ({bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.ifid_flush} !== 4'b1110) begin
      errors++;
      $display("FAIL ld_stall got %b want 1110",
               {bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.ifid_flush});
    end
    advance();
    idle();
    @(negedge clk);
    checks++;
    if (bus.pc_hold !== 1'b0 || bus.state !== 2'd1 || bus.stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL ld_after got hold=%b state=%0d stall=%0d want 0 1 1",
               bus.pc_hold, bus.state, bus.stall_cnt);
    end
    advance();
    $display("load_use: single stall cycle, state LDUSE");
  endtask

  task automatic test_muldiv();
    clear_counters();
    bus.muldiv_start_ID = 1;
    @(negedge clk);
    checks++;
    if (bus.pc_hold !== 1'b0 || bus.muldiv_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_accept got hold=%b busy=%b want 0 0", bus.pc_hold, bus.muldiv_busy);
    end
    advance();
    bus.muldiv_start_ID = 0;
    bus.muldiv_use_ID   = 1;
    for (int i = 0; i <= MDC; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pc_hold !== (i < MDC) || bus.muldiv_busy !== (i < MDC) || dut.md_cnt_reg !== 8'(MDC - i)) begin
        errors++;
        $display("FAIL md_cycle%0d got hold=%b busy=%b md=%0d want %b %b %0d", i,
                 bus.pc_hold, bus.muldiv_busy, dut.md_cnt_reg, i < MDC, i < MDC, MDC - i);
      end
      if (i == 1) begin
        checks++;
        if (bus.state !== 2'd2) begin
          errors++;
          $display("FAIL md_state got %0d want 2", bus.state);
        end
      end
      advance();
    end
    idle();
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'(MDC) || bus.state !== 2'd0) begin
      errors++;
      $display("FAIL md_total got stall=%0d state=%0d want %0d 0", bus.stall_cnt, bus.state, MDC);
    end
    $display("muldiv: %0d stall cycles, dependent op advanced", MDC);
  endtask

  task automatic test_redirect_mdwait();
    clear_counters();
    bus.muldiv_start_ID = 1;
    advance();
    bus.muldiv_start_ID = 0;
    bus.muldiv_use_ID   = 1;
    advance();
    bus.Branch_taken_EX = 1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd2 ||
        {bus.ifid_flush, bus.idex_bubble, bus.pc_hold, bus.ifid_hold} !== 4'b1100) begin
      errors++;
      $display("FAIL redir_mdwait got state=%0d ctl=%b want 2 1100", bus.state,
               {bus.ifid_flush, bus.idex_bubble, bus.pc_hold, bus.ifid_hold});
    end
    advance();
    idle();
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0 || dut.md_cnt_reg !== 8'(MDC - 2) || bus.flush_cnt !== 4'd1) begin
      errors++;
      $display("FAIL redir_after got state=%0d md=%0d flush=%0d want 0 %0d 1",
               bus.state, dut.md_cnt_reg, bus.flush_cnt, MDC - 2);
    end
    repeat (MDC) advance();
    $display("redirect_mdwait: flush wins, md_cnt keeps counting");
  endtask

  task automatic test_no_stall();
    idle();
    bus.MemRd_EX = 1; bus.rt_EX = 0; bus.rs_ID = 0; bus.useRs_ID = 1;
    @(negedge clk);
    checks++;
    if (bus.pc_hold !== 1'b0 || bus.idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg got hold=%b bubble=%b want 0 0", bus.pc_hold, bus.idex_bubble);
    end
    advance();
    idle();
    bus.MemRd_EX = 1; bus.rt_EX = 5'd5; bus.rt_ID = 5'd5; bus.useRt_ID = 0; bus.rs_ID = 5'd6; bus.useRs_ID = 1;
    @(negedge clk);
    checks++;
    if (bus.pc_hold !== 1'b0 || bus.idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL unused_rt got hold=%b bubble=%b want 0 0", bus.pc_hold, bus.idex_bubble);
    end
    advance();
    idle();
    $display("no_stall: $0 load and unused rt do not stall");
  endtask

  task automatic test_async_reset();
    idle();
    bus.muldiv_start_ID = 1;
    advance();
    bus.muldiv_start_ID = 0;
    bus.muldiv_use_ID   = 1;
    advance();
    #2;
    checks++;
    if (dut.md_cnt_reg !== 8'(MDC - 1) || bus.pc_hold !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got md=%0d hold=%b want %0d 1", dut.md_cnt_reg, bus.pc_hold, MDC - 1);
    end
    rst = 0;
    model_reset();
    #1;
    checks++;
    if ({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy} !== 5'b0 ||
        dut.md_cnt_reg !== 8'd0 || bus.state !== 2'd0 || bus.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL areset got ctl=%b md=%0d state=%0d stall=%0d want 00000 0 0 0",
               {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy},
               dut.md_cnt_reg, bus.state, bus.stall_cnt);
    end
    @(negedge clk);
    rst = 1;
    idle();
    @(posedge clk);
    #1;
    $display("async_reset: mid-mul/div stall cancelled without a clock edge");
  endtask

  task automatic test_saturation();
    clear_counters();
    load_use_inputs();
    repeat (CMAX) advance();
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'(CMAX)) begin
      errors++;
      $display("FAIL sat_reach got %0d want %0d", bus.stall_cnt, CMAX);
    end
    advance();
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'(CMAX) || bus.pc_hold !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got stall=%0d hold=%b want %0d 1", bus.stall_cnt, bus.pc_hold, CMAX);
    end
    bus.cnt_clr = 1;
    advance();
    bus.cnt_clr = 0;
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_clr got %0d want 0", bus.stall_cnt);
    end
    advance();
    idle();
    advance();
    $display("saturation: holds at all-ones, clear beats increment");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bus.MemRd_EX        = ($urandom_range(0, 9) < 3);
      bus.rt_EX           = 5'($urandom_range(0, 3));
      bus.rs_ID           = 5'($urandom_range(0, 3));
      bus.rt_ID           = 5'($urandom_range(0, 3));
      bus.useRs_ID        = 1'($urandom_range(0, 1));
      bus.useRt_ID        = 1'($urandom_range(0, 1));
      bus.muldiv_start_ID = ($urandom_range(0, 3) == 0);
      bus.muldiv_use_ID   = ($urandom_range(0, 4) == 0);
      bus.Branch_taken_EX = ($urandom_range(0, 9) == 0);
      bus.JumpReg_EX      = ($urandom_range(0, 19) == 0);
      bus.cnt_clr         = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      model_eval();
      checks++;
      if ({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy} !==
          {e_hold, e_hold, e_flush, e_bubble, 1'(m_md > 0)}) begin
        errors++;
        $display("FAIL rnd%0d_ctl got %b want %b", n,
                 {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy},
                 {e_hold, e_hold, e_flush, e_bubble, 1'(m_md > 0)});
      end
      checks++;
      if (bus.state !== 2'(m_state)) begin
        errors++;
        $display("FAIL rnd%0d_state got %0d want %0d", n, bus.state, m_state);
      end
      checks++;
      if (bus.stall_cnt !== 4'(m_stall) || bus.flush_cnt !== 4'(m_flush)) begin
        errors++;
        $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", n,
                 bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
      end
      $display("rnd %0d: ctl=%b state=%0d stall=%0d flush=%0d", n,
               {bus.pc_hold, bus.ifid_flush, bus.idex_bubble, bus.muldiv_busy},
               bus.state, bus.stall_cnt, bus.flush_cnt);
      advance();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_load_use();
    test_muldiv();
    test_redirect_mdwait();
    test_no_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
